cipher_out_fifo: RTL

Output buffer placed directly downstream of the final encryption round. It captures each 128-bit ciphertext block on a per-block valid strobe and stores it in a small first-word-fall-through FIFO. It presents the blocks to the consumer with a valid/ready handshake. The AES pipeline has no backpressure, so this block absorbs consumer stalls and flags any block lost to overflow.

---
 rtl/aes_pkg.sv | 13 +
 rtl/cipher_out_fifo_if.sv | 22 ++
 rtl/cipher_out_fifo.sv | 115 +++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module : aes_pkg
// Brief  : Shared AES constants and types for the cipher datapath blocks.
// Rev    : 1.0  initial release
// ============================================================================
package aes_pkg;
    localparam int AES_BLOCK_W           = 128;
    localparam int CIPHER_FIFO_DEPTH_DEF = 4;

    typedef logic [AES_BLOCK_W-1:0] aes_block_t;
endpackage
`default_nettype wire

// File: rtl/cipher_out_fifo_if.sv
`default_nettype none
// ============================================================================
// Module : cipher_out_fifo_if
// Brief  : Ciphertext capture strobe plus valid/ready delivery handshake.
// Rev    : 1.0  initial release
// ============================================================================
interface cipher_out_fifo_if
    import aes_pkg::*;
#(
    parameter int BLOCK_LENGTH = AES_BLOCK_W
);
    logic [BLOCK_LENGTH-1:0] IN;
    logic                    in_valid;
    logic [BLOCK_LENGTH-1:0] OUT;
    logic                    out_valid;
    logic                    out_ready;

    // slave is the FIFO itself; master is the pipeline/consumer environment
    modport slave  (input  IN, in_valid, out_ready, output OUT, out_valid);
    modport master (output IN, in_valid, out_ready, input  OUT, out_valid);
endinterface
`default_nettype wire

// File: rtl/cipher_out_fifo.sv
`default_nettype none
// ============================================================================
// Module : cipher_out_fifo
// Brief  : FWFT output buffer for AES ciphertext with sticky overflow flag.
//          Define CIPHER_FIFO_DROP_CNT_EN to add a saturating drop counter.
// Rev    : 1.0  initial release
// ============================================================================
module cipher_out_fifo
    import aes_pkg::*;
#(
    parameter int BLOCK_LENGTH = AES_BLOCK_W,
    parameter int DEPTH        = CIPHER_FIFO_DEPTH_DEF,
    parameter int ADDR_W       = $clog2(DEPTH)
) (
    input  wire logic              clk,
    input  wire logic              rst,
    cipher_out_fifo_if.slave       bus,
    output logic [ADDR_W:0]        count,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    input  wire logic              ovf_clr
`ifdef CIPHER_FIFO_DROP_CNT_EN
    ,
    output logic [15:0]            drop_cnt
`endif
);

    localparam logic [ADDR_W:0] c_full_count = (ADDR_W+1)'(DEPTH);

    logic [BLOCK_LENGTH-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]         count_q,  count_d;
    logic                    ovf_q,    ovf_d;

    logic w_pop;
    logic w_push;
    logic w_drop;

    // Status is decoded straight from the count register, so out_valid
    // never sees out_ready combinationally.
    assign full          = (count_q == c_full_count);
    assign empty         = (count_q == '0);
    assign count         = count_q;
    assign overflow      = ovf_q;
    assign bus.out_valid = !empty;
    assign bus.OUT       = mem_q[rd_ptr_q];

    assign w_pop  = bus.out_valid && bus.out_ready;
    assign w_push = bus.in_valid && (!full || w_pop);
    assign w_drop = bus.in_valid && full && !w_pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        if (w_push && !w_pop)      count_d = count_q + 1'b1;
        else if (w_pop && !w_push) count_d = count_q - 1'b1;

        // A drop in the clearing cycle keeps the flag set
        if (w_drop)       ovf_d = 1'b1;
        else if (ovf_clr) ovf_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            if (w_push) begin
                mem_q[wr_ptr_q] <= bus.IN;
            end
        end
    end

`ifdef CIPHER_FIFO_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (ovf_clr) begin
            drop_cnt_d = w_drop ? 16'd1 : 16'd0;
        end else if (w_drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule
`default_nettype wire
